sysid_boot_checker: RTL and testbench

- Avalon-MM read master that sequences the two-word system-ID slave after reset or on request.
- Reads word 0 (system ID), then word 1 (build timestamp), and compares both against expected parameter values.
- Reports pass, mismatch or timeout to the host-side status/LED logic.
- Sits between reset/boot control and the sysid control slave; it is the slave's only master.

---
 rtl/sysid_boot_checker.sv | 181 ++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker
// Avalon-MM read master that reads the two-word system-ID slave (word 0 = ID,
// word 1 = build timestamp) after reset or on request. It compares both words
// against the expected parameters and reports pass, mismatch or timeout.
//
// Ports:
//   clock, reset_n         single rising-edge clock, synchronous active-low reset
//   start                  one-cycle run request (ignored while busy)
//   avm_*                  Avalon-MM read master towards the sysid slave
//   busy / done            sequence running / finished (done holds until next start)
//   id_ok, ts_ok           captured words equal EXPECTED_ID / EXPECTED_TS
//   timeout_err            every retry timed out
//   id_value, ts_value     last captured words
//   retry_cnt              retries consumed in the current or last run
//
// state | meaning
// IDLE  | waiting for start (or the first cycle after reset when AUTO_START)
// RD_ID | read request on word 0
// WT_ID | word 0 accepted, waiting for readdatavalid (USE_RDV only)
// RD_TS | read request on word 1
// WT_TS | word 1 accepted, waiting for readdatavalid (USE_RDV only)
// CHECK | one cycle compare of the captured words
// DONE  | results valid and held
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter bit          USE_RDV        = 1'b0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_cnt
);

  // One spare count above TIMEOUT_CYCLES: an accept on the last allowed
  // cycle moves to WT_* with the counter already past the limit.
  localparam int            CW     = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    R_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gap, gap_nxt;
  logic          auto_pend, auto_nxt;
  logic          busy_nxt, done_nxt, id_ok_nxt, ts_ok_nxt, tmo_nxt;
  logic [31:0]   id_nxt, ts_nxt;
  logic [3:0]    retry_nxt;
  logic          in_rd, in_wt, accept, capture, launch;

  // After a retry, gap holds avm_read low for one cycle so every attempt is
  // a fresh request on the bus.
  assign in_rd       = (state == RD_ID) || (state == RD_TS);
  assign in_wt       = (state == WT_ID) || (state == WT_TS);
  assign avm_read    = in_rd && !gap;
  assign avm_address = (state == RD_TS) || (state == WT_TS);
  assign accept      = avm_read && !avm_waitrequest;
  assign capture     = USE_RDV ? (in_wt && avm_readdatavalid) : accept;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      gap         <= 1'b0;
      auto_pend   <= AUTO_START;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      retry_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      gap         <= gap_nxt;
      auto_pend   <= auto_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      id_ok       <= id_ok_nxt;
      ts_ok       <= ts_ok_nxt;
      timeout_err <= tmo_nxt;
      id_value    <= id_nxt;
      ts_value    <= ts_nxt;
      retry_cnt   <= retry_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gap_nxt   = gap;
    auto_nxt  = auto_pend;
    busy_nxt  = busy;
    done_nxt  = done;
    id_ok_nxt = id_ok;
    ts_ok_nxt = ts_ok;
    tmo_nxt   = timeout_err;
    id_nxt    = id_value;
    ts_nxt    = ts_value;
    retry_nxt = retry_cnt;
    launch    = 1'b0;

    case (state)
      IDLE: launch = start || auto_pend;
      DONE: launch = start;
      CHECK: begin
        id_ok_nxt = (id_value == EXPECTED_ID);
        ts_ok_nxt = (ts_value == EXPECTED_TS);
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = DONE;
      end
      default: begin
        if (gap) begin
          gap_nxt = 1'b0;
        end else if (capture) begin
          // capture beats a timeout landing on the same cycle
          cnt_nxt = '0;
          if ((state == RD_ID) || (state == WT_ID)) begin
            id_nxt    = avm_readdata;
            state_nxt = RD_TS;
          end else begin
            ts_nxt    = avm_readdata;
            state_nxt = CHECK;
          end
        end else if (USE_RDV && accept) begin
          state_nxt = (state == RD_ID) ? WT_ID : WT_TS;
          cnt_nxt   = cnt + CW'(1);
        end else if (cnt >= T_LAST) begin
          cnt_nxt = '0;
          if (retry_cnt < R_MAX) begin
            retry_nxt = retry_cnt + 4'd1;
            gap_nxt   = 1'b1;
            state_nxt = RD_ID;
          end else begin
            tmo_nxt   = 1'b1;
            id_ok_nxt = 1'b0;
            ts_ok_nxt = 1'b0;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    endcase

    if (launch) begin
      state_nxt = RD_ID;
      cnt_nxt   = '0;
      gap_nxt   = 1'b0;
      auto_nxt  = 1'b0;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      id_ok_nxt = 1'b0;
      ts_ok_nxt = 1'b0;
      tmo_nxt   = 1'b0;
      retry_nxt = '0;
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: two instances (A: USE_RDV=0, auto start,
// short timeout; B: USE_RDV=1, manual start) each with a small slave model.
// Expected run results are queued at stimulus time and popped by a monitor
// on every rising edge of done.
module tb_sysid_boot_checker;
  localparam logic [31:0] EID = 32'h1234_5678;
  localparam logic [31:0] ETS = 32'h5F00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id_ok, ts_ok, tmo;
    logic [31:0] id_v, ts_v;
    logic [3:0]  retry;
    int          n_id, n_ts, n_att;
  } res_t;

  res_t qa[$];
  res_t qb[$];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic res_t mk(input logic iok, input logic tok, input logic tmo,
                              input logic [31:0] iv, input logic [31:0] tv,
                              input logic [3:0] r, input int ni, input int nt, input int na);
    res_t e;
    e.id_ok = iok; e.ts_ok = tok; e.tmo = tmo;
    e.id_v = iv; e.ts_v = tv; e.retry = r;
    e.n_id = ni; e.n_ts = nt; e.n_att = na;
    return e;
  endfunction

  task automatic score(input string t, input res_t a, input res_t e);
    chk({t, "_id_ok"},       80'(a.id_ok), 80'(e.id_ok));
    chk({t, "_ts_ok"},       80'(a.ts_ok), 80'(e.ts_ok));
    chk({t, "_timeout_err"}, 80'(a.tmo),   80'(e.tmo));
    chk({t, "_id_value"},    80'(a.id_v),  80'(e.id_v));
    chk({t, "_ts_value"},    80'(a.ts_v),  80'(e.ts_v));
    chk({t, "_retry_cnt"},   80'(a.retry), 80'(e.retry));
    chk({t, "_id_reads"},    80'(a.n_id),  80'(e.n_id));
    chk({t, "_ts_reads"},    80'(a.n_ts),  80'(e.n_ts));
    chk({t, "_attempts"},    80'(a.n_att), 80'(e.n_att));
  endtask

  // ---------------- instance A ----------------
  logic        a_rst_n, a_start, a_addr, a_read, a_wait, a_rdv;
  logic [31:0] a_rdata, a_id_v, a_ts_v;
  logic        a_busy, a_done, a_id_ok, a_ts_ok, a_tmo;
  logic [3:0]  a_retry;
  logic [31:0] a_id_word = EID;
  logic [31:0] a_ts_word = ETS;
  logic        a_stuck = 1'b0;
  int          a_wait_n = 0;
  int          a_wcnt = 0, a_nid = 0, a_nts = 0, a_att = 0, a_stab = 0;
  logic        a_read_q = 1'b0, a_hold = 1'b0, a_hold_addr = 1'b0, a_done_q = 1'b0;

  assign a_rdv   = 1'b0;
  assign a_wait  = a_stuck || (a_read && (a_wcnt < a_wait_n));
  assign a_rdata = a_addr ? a_ts_word : a_id_word;

  sysid_boot_checker #(
    .EXPECTED_ID(EID), .EXPECTED_TS(ETS), .USE_RDV(1'b0),
    .TIMEOUT_CYCLES(8), .MAX_RETRIES(2), .AUTO_START(1'b1)
  ) dut_a (
    .clock(clk), .reset_n(a_rst_n), .start(a_start),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_wait),
    .avm_readdata(a_rdata), .avm_readdatavalid(a_rdv),
    .busy(a_busy), .done(a_done), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
    .timeout_err(a_tmo), .id_value(a_id_v), .ts_value(a_ts_v), .retry_cnt(a_retry)
  );

  always @(posedge clk) begin
    a_wcnt <= (a_read && a_wait) ? a_wcnt + 1 : 0;
    if (a_read && !a_wait) begin
      if (a_addr) a_nts <= a_nts + 1;
      else        a_nid <= a_nid + 1;
    end
    if (a_read && !a_read_q) a_att <= a_att + 1;
    a_read_q <= a_read;
    if (a_hold && (!a_read || (a_addr != a_hold_addr))) a_stab <= a_stab + 1;
    a_hold      <= a_read && a_wait;
    a_hold_addr <= a_addr;
  end

  always @(negedge clk) begin : mon_a
    res_t e, a;
    if (a_done === 1'b1 && a_done_q !== 1'b1) begin
      if (qa.size() == 0) begin
        chk("A_unexpected_done", 80'(1), 80'(0));
      end else begin
        e = qa.pop_front();
        a = mk(a_id_ok, a_ts_ok, a_tmo, a_id_v, a_ts_v, a_retry, a_nid, a_nts, a_att);
        score("A", a, e);
      end
    end
    a_done_q <= a_done;
  end

  // ---------------- instance B ----------------
  logic        b_rst_n, b_start, b_addr, b_read, b_wait, b_rdv;
  logic [31:0] b_rdata, b_id_v, b_ts_v;
  logic        b_busy, b_done, b_id_ok, b_ts_ok, b_tmo;
  logic [3:0]  b_retry;
  int          b_dly = 0, b_nid = 0, b_nts = 0, b_att = 0, b_wtrd = 0;
  logic        b_paddr = 1'b0, b_read_q = 1'b0, b_done_q = 1'b0;

  assign b_wait  = 1'b0;
  assign b_rdv   = (b_dly == 1);
  assign b_rdata = b_paddr ? ETS : EID;

  sysid_boot_checker #(
    .EXPECTED_ID(EID), .EXPECTED_TS(ETS), .USE_RDV(1'b1),
    .TIMEOUT_CYCLES(255), .MAX_RETRIES(3), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clk), .reset_n(b_rst_n), .start(b_start),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(b_wait),
    .avm_readdata(b_rdata), .avm_readdatavalid(b_rdv),
    .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
    .timeout_err(b_tmo), .id_value(b_id_v), .ts_value(b_ts_v), .retry_cnt(b_retry)
  );

  // readdatavalid arrives 3 cycles after the accept edge
  always @(posedge clk) begin
    if (b_read && !b_wait) begin
      b_dly   <= 3;
      b_paddr <= b_addr;
      if (b_addr) b_nts <= b_nts + 1;
      else        b_nid <= b_nid + 1;
    end else if (b_dly != 0) begin
      b_dly <= b_dly - 1;
    end
    if (b_read && !b_read_q) b_att <= b_att + 1;
    b_read_q <= b_read;
  end

  always @(negedge clk) begin
    if (b_dly != 0 && b_read === 1'b1) b_wtrd <= b_wtrd + 1;
  end

  always @(negedge clk) begin : mon_b
    res_t e, a;
    if (b_done === 1'b1 && b_done_q !== 1'b1) begin
      if (qb.size() == 0) begin
        chk("B_unexpected_done", 80'(1), 80'(0));
      end else begin
        e = qb.pop_front();
        a = mk(b_id_ok, b_ts_ok, b_tmo, b_id_v, b_ts_v, b_retry, b_nid, b_nts, b_att);
        score("B", a, e);
      end
    end
    b_done_q <= b_done;
  end

  // ---------------- stimulus ----------------
  task automatic pulse_a();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic pulse_b();
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() != 0) begin
      chk("A_done_wait_expired", 80'(qa.size()), 80'(0));
      qa.delete();
    end
  endtask

  task automatic drain_b();
    int n = 0;
    while (qb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (qb.size() != 0) begin
      chk("B_done_wait_expired", 80'(qb.size()), 80'(0));
      qb.delete();
    end
  endtask

  initial begin : stim
    int bstab, bwt, n, bid, bts;
    a_rst_n = 1'b0; a_start = 1'b0;
    b_rst_n = 1'b0; b_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("A_reset_outputs", 80'({a_read, a_addr, a_busy, a_done, a_id_ok, a_ts_ok, a_tmo,
                                a_id_v, a_ts_v, a_retry}), 80'(0));
    chk("B_reset_outputs", 80'({b_read, b_addr, b_busy, b_done, b_id_ok, b_ts_ok, b_tmo,
                                b_id_v, b_ts_v, b_retry}), 80'(0));

    // A1: auto start, zero-wait, back-to-back reads, done within 4 cycles
    qa.push_back(mk(1, 1, 0, EID, ETS, 0, a_nid + 1, a_nts + 1, a_att + 1));
    a_rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("A_done_within_4", 80'(a_done), 80'(1));
    drain_a();

    // A2: ID mismatch, no retry
    a_id_word = 32'h1234_5679;
    qa.push_back(mk(0, 1, 0, 32'h1234_5679, ETS, 0, a_nid + 1, a_nts + 1, a_att + 1));
    pulse_a();
    drain_a();

    // A3: 5 wait states on each read
    a_id_word = EID;
    a_wait_n  = 5;
    bstab     = a_stab;
    qa.push_back(mk(1, 1, 0, EID, ETS, 0, a_nid + 1, a_nts + 1, a_att + 1));
    pulse_a();
    drain_a();
    chk("A_wait_stable", 80'(a_stab - bstab), 80'(0));

    // A4: waitrequest stuck: 3 attempts then timeout_err
    a_wait_n = 0;
    a_stuck  = 1'b1;
    qa.push_back(mk(0, 0, 1, EID, ETS, 2, a_nid, a_nts, a_att + 3));
    pulse_a();
    drain_a();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("A_read_low_after_timeout", 80'(a_read), 80'(0));
    end

    // B: manual start, no activity until start
    b_rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("B_idle_no_read", 80'(b_read), 80'(0));
    chk("B_idle_not_busy", 80'(b_busy), 80'(0));

    // B1: readdatavalid 3 cycles after accept
    bwt = b_wtrd;
    qb.push_back(mk(1, 1, 0, EID, ETS, 0, b_nid + 1, b_nts + 1, b_att + 2));
    pulse_b();
    drain_b();
    chk("B_read_low_in_wait", 80'(b_wtrd - bwt), 80'(0));

    // B2: reset while in WT_TS
    pulse_b();
    n = 0;
    while (!(b_addr === 1'b1 && b_read === 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("B_reached_wt_ts", 80'(b_addr === 1'b1 && b_read === 1'b0), 80'(1));
    b_rst_n = 1'b0;
    @(negedge clk);
    chk("B_abort_outputs", 80'({b_read, b_addr, b_busy, b_done, b_id_ok, b_ts_ok, b_tmo,
                                b_id_v, b_ts_v, b_retry}), 80'(0));
    b_rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("B_post_reset_no_read", 80'(b_read), 80'(0));
    chk("B_post_reset_not_done", 80'(b_done), 80'(0));

    // B3: full run with a start during busy ignored
    qb.push_back(mk(1, 1, 0, EID, ETS, 0, b_nid + 1, b_nts + 1, b_att + 2));
    pulse_b();
    repeat (3) @(negedge clk);
    chk("B_busy_mid_run", 80'(b_busy), 80'(1));
    pulse_b();
    drain_b();
    bid = b_nid;
    bts = b_nts;
    repeat (10) @(negedge clk);
    chk("B_done_held", 80'(b_done), 80'(1));
    chk("B_no_extra_reads", 80'((b_nid - bid) + (b_nts - bts)), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
